// File: rtl/cpu_pkg.sv
// Shared definitions for the stack-frame sequencer: op codes, register
// access codes, word size and the sequencer state encoding.
package cpu_pkg;

    localparam logic [1:0]  OP_ENTER  = 2'b01;
    localparam logic [1:0]  OP_LEAVE  = 2'b10;

    localparam logic [3:0]  RW_IDLE   = 4'h0;
    localparam logic [3:0]  RW_WRITE  = 4'h2;

    localparam logic [31:0] WORD_SIZE = 32'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH,
        ST_POP,
        ST_SET_FRAME,
        ST_RESTORE,
        ST_FIN
    } state_t;

endpackage

// File: rtl/frame_controller_if.sv
// Data-memory request port: the sequencer is the master, memory the slave.
interface frame_controller_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Saturating wait counter for an outstanding memory request. 'expired' is
// high in the last cycle the request may stay pending without mem_ready.
module mem_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] count;

    // Count stall cycles, holding at the limit until cleared.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/frame_controller.sv
// ENTER/LEAVE sequencer: pushes/pops ebp through the memory port and then
// updates ebp and esp together in a single cycle, so a faulted operation
// never touches either register.
module frame_controller
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [1:0]                op,
    input  logic [15:0]               alloc_size,
    input  logic [31:0]               esp_in,
    input  logic [31:0]               ebp_in,
    output logic                      busy,
    output logic                      done,
    output logic                      fault,
    output logic [3:0]                ebp_rw,
    output logic [31:0]               ebp_wdata,
    output logic                      esp_we,
    output logic [31:0]               esp_wdata,
    frame_controller_if.master        mem
);

    state_t      state, state_d;
    logic        fault_q, fault_d;
    logic [31:0] sp, bp, rdata_q;
    logic [15:0] alloc_q;
    logic        expired;

    // The timer is cleared while idle, which covers every entry to PUSH/POP.
    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (state == ST_IDLE),
        .enable  ((state == ST_PUSH || state == ST_POP) && !mem.mem_ready),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_d;
    end

    // Operand latches, popped word and the abort flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fault_q <= 1'b0;
            sp      <= '0;
            bp      <= '0;
            alloc_q <= '0;
            rdata_q <= '0;
        end else begin
            fault_q <= fault_d;
            if (state == ST_IDLE && start) begin
                sp      <= esp_in;
                bp      <= ebp_in;
                alloc_q <= alloc_size;
            end
            if (state == ST_POP && mem.mem_ready) begin
                rdata_q <= mem.mem_rdata;
            end
        end
    end

    // Next-state logic and outputs decoded from state plus latched operands.
    always_comb begin
        state_d       = state;
        fault_d       = fault_q;
        busy          = (state != ST_IDLE);
        done          = 1'b0;
        fault         = 1'b0;
        ebp_rw        = RW_IDLE;
        ebp_wdata     = '0;
        esp_we        = 1'b0;
        esp_wdata     = '0;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    fault_d = 1'b0;
                    case (op)
                        OP_ENTER: begin
                            if (esp_in[1:0] != 2'b00) begin
                                fault_d = 1'b1;
                                state_d = ST_FIN;
                            end else begin
                                state_d = ST_PUSH;
                            end
                        end
                        OP_LEAVE: begin
                            if (ebp_in[1:0] != 2'b00) begin
                                fault_d = 1'b1;
                                state_d = ST_FIN;
                            end else begin
                                state_d = ST_POP;
                            end
                        end
                        default: begin
                            fault_d = 1'b1;
                            state_d = ST_FIN;
                        end
                    endcase
                end
            end
            ST_PUSH: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = sp - WORD_SIZE;
                mem.mem_wdata = bp;
                if (mem.mem_ready) begin
                    state_d = ST_SET_FRAME;
                end else if (expired) begin
                    fault_d = 1'b1;
                    state_d = ST_FIN;
                end
            end
            ST_POP: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = bp;
                if (mem.mem_ready) begin
                    state_d = ST_RESTORE;
                end else if (expired) begin
                    fault_d = 1'b1;
                    state_d = ST_FIN;
                end
            end
            ST_SET_FRAME: begin
                ebp_rw    = RW_WRITE;
                ebp_wdata = sp - WORD_SIZE;
                esp_we    = 1'b1;
                esp_wdata = sp - WORD_SIZE - {16'h0000, alloc_q};
                state_d   = ST_FIN;
            end
            ST_RESTORE: begin
                ebp_rw    = RW_WRITE;
                ebp_wdata = rdata_q;
                esp_we    = 1'b1;
                esp_wdata = bp + WORD_SIZE;
                state_d   = ST_FIN;
            end
            ST_FIN: begin
                done    = 1'b1;
                fault   = fault_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_frame_controller.sv
// Directed bench for frame_controller (built with TIMEOUT=8).
module tb_frame_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] alloc_size = '0;
    logic [31:0] esp_in = '0;
    logic [31:0] ebp_in = '0;
    logic        busy, done, fault, esp_we;
    logic [3:0]  ebp_rw;
    logic [31:0] ebp_wdata, esp_wdata;

    int n_cmp = 0;
    int n_err = 0;

    frame_controller_if mem ();

    frame_controller #(.TIMEOUT(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .alloc_size (alloc_size),
        .esp_in     (esp_in),
        .ebp_in     (ebp_in),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .ebp_rw     (ebp_rw),
        .ebp_wdata  (ebp_wdata),
        .esp_we     (esp_we),
        .esp_wdata  (esp_wdata),
        .mem        (mem)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        mem.mem_ready = 1'b0;
        mem.mem_rdata = '0;
        tick();
        n_cmp++; if ({busy, done, fault, esp_we, mem.mem_req, mem.mem_we} !== 6'b0) begin n_err++; $display("FAIL reset_ctrl: got %b want 000000", {busy, done, fault, esp_we, mem.mem_req, mem.mem_we}); end
        n_cmp++; if (ebp_rw !== 4'h0) begin n_err++; $display("FAIL reset_ebp_rw: got %h want 0", ebp_rw); end
        n_cmp++; if ({ebp_wdata, esp_wdata, mem.mem_addr, mem.mem_wdata} !== 128'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", {ebp_wdata, esp_wdata, mem.mem_addr, mem.mem_wdata}); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_enter();
        esp_in = 32'h0000_1000; ebp_in = 32'h0000_0999; alloc_size = 16'h0010;
        op = 2'b01; start = 1'b1; mem.mem_ready = 1'b1;
        tick(); start = 1'b0;                                   // T+1
        n_cmp++; if ({mem.mem_req, mem.mem_we, busy} !== 3'b111) begin n_err++; $display("FAIL enter_req: got %b want 111", {mem.mem_req, mem.mem_we, busy}); end
        n_cmp++; if (mem.mem_addr !== 32'h0000_0FFC) begin n_err++; $display("FAIL enter_addr: got %h want 00000ffc", mem.mem_addr); end
        n_cmp++; if (mem.mem_wdata !== 32'h0000_0999) begin n_err++; $display("FAIL enter_wdata: got %h want 00000999", mem.mem_wdata); end
        tick();                                                 // T+2
        n_cmp++; if ({ebp_rw, esp_we, mem.mem_req} !== 6'b0010_1_0) begin n_err++; $display("FAIL enter_strobes: got %b want 001010", {ebp_rw, esp_we, mem.mem_req}); end
        n_cmp++; if (ebp_wdata !== 32'h0000_0FFC) begin n_err++; $display("FAIL enter_ebp: got %h want 00000ffc", ebp_wdata); end
        n_cmp++; if (esp_wdata !== 32'h0000_0FEC) begin n_err++; $display("FAIL enter_esp: got %h want 00000fec", esp_wdata); end
        tick();                                                 // T+3
        n_cmp++; if ({done, fault, busy, esp_we} !== 4'b1010) begin n_err++; $display("FAIL enter_done: got %b want 1010", {done, fault, busy, esp_we}); end
        tick();
        n_cmp++; if ({done, busy} !== 2'b00) begin n_err++; $display("FAIL enter_idle: got %b want 00", {done, busy}); end
        mem.mem_ready = 1'b0;
    endtask

    task automatic test_leave_stall();
        esp_in = 32'h0000_0FEC; ebp_in = 32'h0000_0FFC; alloc_size = 16'h0;
        op = 2'b10; start = 1'b1; mem.mem_ready = 1'b0; mem.mem_rdata = 32'hDEAD_BEEF;
        tick(); start = 1'b0;                                   // T+1..T+3 stall
        for (int i = 1; i <= 3; i++) begin
            n_cmp++; if ({mem.mem_req, mem.mem_we, mem.mem_addr} !== {2'b10, 32'h0000_0FFC}) begin n_err++; $display("FAIL leave_hold%0d: got %b %b %h want 1 0 00000ffc", i, mem.mem_req, mem.mem_we, mem.mem_addr); end
            n_cmp++; if ({done, ebp_rw, esp_we} !== 6'b0) begin n_err++; $display("FAIL leave_quiet%0d: got %b want 0", i, {done, ebp_rw, esp_we}); end
            if (i < 3) tick();
            else begin tick(); mem.mem_ready = 1'b1; mem.mem_rdata = 32'h0000_0999; end
        end
        n_cmp++; if (mem.mem_addr !== 32'h0000_0FFC) begin n_err++; $display("FAIL leave_ready_addr: got %h want 00000ffc", mem.mem_addr); end
        tick(); mem.mem_ready = 1'b0; mem.mem_rdata = 32'h1111_1111; // T+5
        n_cmp++; if ({ebp_rw, esp_we} !== 5'b0010_1) begin n_err++; $display("FAIL leave_strobes: got %b want 00101", {ebp_rw, esp_we}); end
        n_cmp++; if (ebp_wdata !== 32'h0000_0999) begin n_err++; $display("FAIL leave_ebp: got %h want 00000999", ebp_wdata); end
        n_cmp++; if (esp_wdata !== 32'h0000_1000) begin n_err++; $display("FAIL leave_esp: got %h want 00001000", esp_wdata); end
        tick();                                                 // T+6
        n_cmp++; if ({done, fault} !== 2'b10) begin n_err++; $display("FAIL leave_done: got %b want 10", {done, fault}); end
        tick();
    endtask

    task automatic test_early_fault();
        logic [1:0]  ops  [2];
        logic [31:0] esps [2];
        ops[0] = 2'b01; esps[0] = 32'h0000_1002;
        ops[1] = 2'b11; esps[1] = 32'h0000_1000;
        for (int k = 0; k < 2; k++) begin
            esp_in = esps[k]; ebp_in = 32'h0000_0800; op = ops[k]; start = 1'b1;
            tick(); start = 1'b0;                               // T+1
            n_cmp++; if ({done, fault, busy} !== 3'b111) begin n_err++; $display("FAIL early%0d_done: got %b want 111", k, {done, fault, busy}); end
            n_cmp++; if ({mem.mem_req, ebp_rw, esp_we} !== 6'b0) begin n_err++; $display("FAIL early%0d_writes: got %b want 0", k, {mem.mem_req, ebp_rw, esp_we}); end
            tick();
            n_cmp++; if ({done, busy} !== 2'b00) begin n_err++; $display("FAIL early%0d_idle: got %b want 00", k, {done, busy}); end
        end
    endtask

    task automatic test_timeout();
        int wrote = 0;
        int req_cycles = 0;
        esp_in = 32'h0000_2000; ebp_in = 32'h0000_3000; alloc_size = 16'h20;
        op = 2'b01; start = 1'b1; mem.mem_ready = 1'b0;
        tick(); start = 1'b0;                                   // T+1 first request
        for (int i = 0; i < 8; i++) begin
            if (mem.mem_req && mem.mem_addr == 32'h0000_1FFC && mem.mem_wdata == 32'h0000_3000 && !done) req_cycles++;
            if (ebp_rw != 4'h0 || esp_we) wrote++;
            tick();
        end                                                     // T+9
        n_cmp++; if (req_cycles !== 8) begin n_err++; $display("FAIL tmo_held: got %0d want 8", req_cycles); end
        n_cmp++; if ({done, fault, mem.mem_req} !== 3'b110) begin n_err++; $display("FAIL tmo_fault: got %b want 110", {done, fault, mem.mem_req}); end
        n_cmp++; if (wrote !== 0 || ebp_rw !== 4'h0 || esp_we !== 1'b0) begin n_err++; $display("FAIL tmo_writes: got %0d want 0", wrote); end
        tick();
        n_cmp++; if ({busy, mem.mem_req} !== 2'b00) begin n_err++; $display("FAIL tmo_idle: got %b want 00", {busy, mem.mem_req}); end
    endtask

    task automatic test_wrap();
        esp_in = 32'h0; ebp_in = 32'h0000_1234; alloc_size = 16'hFFFF;
        op = 2'b01; start = 1'b1; mem.mem_ready = 1'b1;
        tick(); start = 1'b0;
        n_cmp++; if (mem.mem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr: got %h want fffffffc", mem.mem_addr); end
        tick();
        n_cmp++; if (esp_wdata !== 32'hFFFE_FFFD) begin n_err++; $display("FAIL wrap_esp: got %h want fffefffd", esp_wdata); end
        n_cmp++; if (ebp_wdata !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_ebp: got %h want fffffffc", ebp_wdata); end
        tick();
        n_cmp++; if ({done, fault} !== 2'b10) begin n_err++; $display("FAIL wrap_done: got %b want 10", {done, fault}); end
        tick(); mem.mem_ready = 1'b0;
    endtask

    task automatic test_reset_mid_and_ignore();
        int dones = 0;
        int writes = 0;
        esp_in = 32'h0000_4000; ebp_in = 32'h0000_5000; op = 2'b10; start = 1'b1; mem.mem_ready = 1'b0;
        tick(); start = 1'b0;
        tick();                                                 // still stalled in POP
        reset = 1'b0; #1;
        n_cmp++; if ({busy, done, fault, mem.mem_req, ebp_rw, esp_we} !== 9'b0) begin n_err++; $display("FAIL rst_mid_outs: got %b want 0", {busy, done, fault, mem.mem_req, ebp_rw, esp_we}); end
        n_cmp++; if (mem.mem_addr !== 32'h0) begin n_err++; $display("FAIL rst_mid_addr: got %h want 0", mem.mem_addr); end
        tick(); reset = 1'b1; mem.mem_ready = 1'b1; mem.mem_rdata = 32'hAAAA_0000;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (busy || esp_we || ebp_rw != 4'h0 || mem.mem_req) writes++;
        end
        n_cmp++; if (writes !== 0) begin n_err++; $display("FAIL rst_replay: got %0d want 0", writes); end
        esp_in = 32'h0000_1000; ebp_in = 32'h0000_0999; alloc_size = 16'h8; op = 2'b01; start = 1'b1;
        tick();                                                 // T+1 busy, start held (ignored)
        op = 2'b10; ebp_in = 32'h0000_0004;
        tick(); start = 1'b0;                                   // T+2
        n_cmp++; if (esp_wdata !== 32'h0000_0FF4) begin n_err++; $display("FAIL ign_esp: got %h want 00000ff4", esp_wdata); end
        start = 1'b1;                                           // pulse during FIN
        for (int i = 0; i < 5; i++) begin
            tick();
            start = 1'b0;
            if (done) dones++;
        end
        n_cmp++; if (dones !== 1) begin n_err++; $display("FAIL ign_once: got %0d want 1", dones); end
        n_cmp++; if ({busy, mem.mem_req} !== 2'b00) begin n_err++; $display("FAIL ign_idle: got %b want 00", {busy, mem.mem_req}); end
        mem.mem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_enter();
        test_leave_stall();
        test_early_fault();
        test_timeout();
        test_wrap();
        test_reset_mid_and_ignore();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
